clkdiv_prog: RTL
================

# clkdiv_prog

Parametrised, fully synchronous programmable clock divider. A WIDTH-bit terminal-count counter produces a one-cycle `tick` enable every `div+1` enabled cycles and a toggling `clk_out` square wave. An optional binary divider chain is built from enable-gated T-stages. The block feeds slow-strobe logic such as LED blink, debounce and UART-baud domains; all downstream logic stays on `clk` and uses `tick` as a clock enable.

## Interface
Parameters:
- `WIDTH`, 8, counter and divisor width; ratio range 1..2^WIDTH
- `STAGES`, 2, length of the optional T-stage chain (≥1)

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  reset; synchronous, active-high
- `en`  in  1  count enable; low freezes all state
- `div`  in  WIDTH  terminal count; divide ratio = `div`+1
- `load`  in  1  one-cycle request to adopt `div` as the new terminal count
- `count`  out  WIDTH  current counter value
- `tick`  out  1  registered one-cycle pulse at each wrap
- `clk_out`  out  1  toggles on every `tick`; period 2·(`div`+1) cycles
- `stage_q`  out  STAGES  divider chain; present only with `CLKDIV_STAGES_EN`

## Operation
- Internal state:
  - `div_q`: active terminal count
  - `pend_q` / `pend_v`: pending divisor and its valid flag
- Reset (`rst`=1 at an edge):
  - `count`=0, `tick`=0, `clk_out`=0, `stage_q`=0, `pend_v`=0
  - `div_q` ← `div` as sampled in that cycle
  - Any pending load is discarded.
- Enabled cycle (`en`=1):
  - `count`≠`div_q`: `count` ← `count`+1, `tick` ← 0.
  - `count`==`div_q` (wrap): `count` ← 0, `tick` ← 1, `clk_out` ← ~`clk_out`.
  - At a wrap with `pend_v`=1: `div_q` ← `pend_q`, `pend_v` ← 0.
- Disabled cycle (`en`=0):
  - `count`, `clk_out`, `stage_q` and `div_q` hold; `tick` ← 0.
  - Loads are still captured.
- Load handling:
  - `load`=1 sets `pend_q` ← `div` and `pend_v` ← 1. If several loads arrive before a wrap, the last one wins.
  - `load` in the same cycle as a wrap: the new `div` goes straight to `div_q` at that wrap, and `pend_v` ends at 0.
  - `div_q` never changes mid-period, so `count` ≤ `div_q` always holds.
- `div`=0: `tick` is high on every enabled cycle and `clk_out` is `clk`/2.
- Arithmetic: unsigned. `count` never exceeds `div_q`, so there is no overflow path.

## Timing
- After reset release with `en`=1, the first `tick` is high during cycle `div`+1 (cycles numbered from 0 at the first enabled edge).
- Subsequent ticks are exactly `div_q`+1 enabled cycles apart. Cycles with `en`=0 stretch the period one for one.
- `tick`, `clk_out` and `stage_q` are registered and change on the same edge; there is no combinational path from any input to any output.
- Load latency: the new ratio takes effect at the first wrap after the load (0 cycles if the load is coincident with a wrap). The maximum is one old period.
- `rst` overrides `en` and `load` in the same cycle.

## Configuration
- Macro: `CLKDIV_STAGES_EN`.
- Defined:
  - The `stage_q` port and an STAGES-long chain of enable-gated T-stages are present.
  - Stage 0 toggles on a wrap where `clk_out` is 1 before the edge, i.e. the falling transition of `clk_out`.
  - Stage i toggles when stage i-1 falls in the same update.
  - `stage_q` is therefore a binary up-count of `clk_out` periods, modulo 2^STAGES, and is fully synchronous.
- Undefined: the `stage_q` port and the chain are absent. All other behaviour is identical.

## Structure
- Package `clkdiv_pkg`: default `WIDTH`/`STAGES` constants and a `clkdiv_ratio_t` typedef (logic [WIDTH-1:0] at default width).
- Sub-module `clkdiv_tstage`:
  - Synchronous T flip-flop with ports `clk`, `rst`, `ce`, `t`, `q`.
  - `q` ← `q`^`t` when `ce`=1.
  - Instantiated once for `clk_out` and STAGES times for the chain.

## Test plan
- Reset, `div`=3, `en`=1 → `count` runs 0,1,2,3,0…; `tick` high during cycles 4, 8, 12; `clk_out` 0→1 at cycle 4 and 1→0 at cycle 8.
- `div`=0, `en`=1 → `tick` constantly 1; `clk_out` alternates 1,0,1,0 from cycle 1.
- Running with `div_q`=5; `load` with `div`=2 at `count`=1 → one more 6-cycle period completes, then ticks every 3 cycles. A second load with `div`=7 before the wrap supersedes the first, giving ratio 8.
- `en` low for 4 cycles at `count`=2 (`div_q`=4) → `count` holds at 2, `tick`=0; after re-enable the next tick arrives 3 enabled cycles later, with the period stretched by 4.
- `rst` asserted at `count`=6 with `pend_v`=1 → next cycle all outputs are 0, `div_q` equals the sampled `div`, and the pending value is never applied.
- With `CLKDIV_STAGES_EN`, `STAGES`=2, `div`=1 → `stage_q` steps 0,1,2,3,0 every 4 cycles (one step per `clk_out` period), wrapping at cycle 16 after reset release.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared defaults and types for the programmable clock divider.
package clkdiv_pkg;

  localparam int unsigned CLKDIV_WIDTH  = 8;
  localparam int unsigned CLKDIV_STAGES = 2;

  typedef logic [CLKDIV_WIDTH-1:0] clkdiv_ratio_t;

endpackage

// File: rtl/clkdiv_tstage.sv
// Synchronous enable-gated T flip-flop used for clk_out and the binary divider chain.
module clkdiv_tstage (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic t,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 1'b0;
    end else if (ce) begin
      r_q <= r_q ^ t;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/clkdiv_prog.sv
// Programmable terminal-count divider producing a tick enable and a clk_out square wave.
// Optional T-stage chain on stage_q is built when CLKDIV_STAGES_EN is defined.
module clkdiv_prog
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH  = CLKDIV_WIDTH,
  parameter int unsigned STAGES = CLKDIV_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  input  logic             load,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             clk_out
`ifdef CLKDIV_STAGES_EN
  ,
  output logic [STAGES-1:0] stage_q
`endif
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_div_q;
  logic [WIDTH-1:0] r_pend_q;
  logic             r_pend_v;
  logic             r_tick;
  logic             w_wrap;
  logic             w_clk_out;

  assign w_wrap = en && (r_count == r_div_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_tick   <= 1'b0;
      r_div_q  <= div;
      r_pend_v <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (en) begin
        r_count <= w_wrap ? '0 : r_count + 1'b1;
      end
      // A load coincident with the wrap bypasses the pending register.
      if (w_wrap) begin
        r_pend_v <= 1'b0;
        if (load) begin
          r_div_q <= div;
        end else if (r_pend_v) begin
          r_div_q <= r_pend_q;
        end
      end else if (load) begin
        r_pend_v <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      r_pend_q <= div;
    end
  end

  clkdiv_tstage u_clk_out (
    .clk (clk),
    .rst (rst),
    .ce  (en),
    .t   (w_wrap),
    .q   (w_clk_out)
  );

  assign count   = r_count;
  assign tick    = r_tick;
  assign clk_out = w_clk_out;

`ifdef CLKDIV_STAGES_EN
  logic [STAGES-1:0] w_stage_t;
  logic [STAGES-1:0] w_stage_q;

  // Stage 0 advances on clk_out falling; each later stage on its predecessor falling.
  assign w_stage_t[0] = w_wrap & w_clk_out;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi > 0) begin : g_carry
      assign w_stage_t[gi] = w_stage_t[gi-1] & w_stage_q[gi-1];
    end
    clkdiv_tstage u_tstage (
      .clk (clk),
      .rst (rst),
      .ce  (en),
      .t   (w_stage_t[gi]),
      .q   (w_stage_q[gi])
    );
  end

  assign stage_q = w_stage_q;
`endif

endmodule
